// File: rtl/load_control_seq_pkg.sv
// load_control_seq_pkg: load/store type encodings and load FSM states shared by the load path
package load_control_seq_pkg;
    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_t;
endpackage

// File: rtl/load_control_seq_if.sv
// load_control_seq_if: request, memory and result signals of the load unit
interface load_control_seq_if;
    logic        start;
    logic [1:0]  LS_control;
    logic [31:0] addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        busy;
    logic        done;
    logic [31:0] LS_out;
    logic [31:0] mdr_out;
    modport master (
        output start, LS_control, addr, mem_data_in,
        input  mem_addr, mem_rd, busy, done, LS_out, mdr_out
    );
    modport slave (
        input  start, LS_control, addr, mem_data_in,
        output mem_addr, mem_rd, busy, done, LS_out, mdr_out
    );
endinterface

// File: rtl/load_format.sv
// load_format: selects the low word/half/byte of a fetched word and fills the upper bits
module load_format
    import load_control_seq_pkg::*;
#(
    parameter bit SIGN_EXT = 1'b0
) (
    input  logic [31:0] word,
    input  logic [1:0]  ls_type,
    output logic [31:0] formatted
);
    logic [15:0] fill_h;
    logic [23:0] fill_b;
    always_comb begin
        fill_h    = SIGN_EXT ? {16{word[15]}} : 16'h0;
        fill_b    = SIGN_EXT ? {24{word[7]}} : 24'h0;
        formatted = ls_type == LS_HALF ? {fill_h, word[15:0]} :
                    ls_type == LS_BYTE ? {fill_b, word[7:0]} : word;
    end
endmodule

// File: rtl/load_control_seq.sv
// load_control_seq: one memory read per request, fixed latency, formatted lw/lh/lb result
module load_control_seq
    import load_control_seq_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter bit SIGN_EXT    = 1'b0
) (
    input logic               clk,
    input logic               reset,
    load_control_seq_if.slave bus
);
    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  type_q;
    logic [31:0] fmt;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        busy;
    logic        done;
    logic [31:0] ls_out;
    logic [31:0] mdr_out;

    load_format #(.SIGN_EXT(SIGN_EXT)) u_fmt (
        .word      (bus.mem_data_in),
        .ls_type   (type_q),
        .formatted (fmt)
    );

    // the counter is reloaded in REQ so WAIT lasts exactly MEM_LATENCY cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            type_q   <= LS_WORD;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ls_out   <= '0;
            mdr_out  <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    mem_addr <= bus.addr;
                    type_q   <= bus.LS_control;
                    mem_rd   <= 1'b1;
                    busy     <= 1'b1;
                    state    <= S_REQ;
                end
                S_REQ: begin
                    mem_rd <= 1'b0;
                    cnt    <= 4'(MEM_LATENCY - 1);
                    state  <= S_WAIT;
                end
                S_WAIT: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    mdr_out <= bus.mem_data_in;
                    ls_out  <= fmt;
                    done    <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr = mem_addr;
    assign bus.mem_rd   = mem_rd;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.LS_out   = ls_out;
    assign bus.mdr_out  = mdr_out;
endmodule

// File: tb/tb_load_control_seq.sv
// tb_load_control_seq: directed vectors on two latency-1 units (zero/sign fill) and one latency-3 unit
module tb_load_control_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    load_control_seq_if i0 ();
    load_control_seq_if i1 ();
    load_control_seq_if i2 ();

    load_control_seq #(.MEM_LATENCY(1), .SIGN_EXT(1'b0)) d0 (.clk(clk), .reset(reset), .bus(i0.slave));
    load_control_seq #(.MEM_LATENCY(1), .SIGN_EXT(1'b1)) d1 (.clk(clk), .reset(reset), .bus(i1.slave));
    load_control_seq #(.MEM_LATENCY(3), .SIGN_EXT(1'b1)) d2 (.clk(clk), .reset(reset), .bus(i2.slave));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  ctl;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_pair(input int idx, input vec_t v);
        int n, rd0, rd1;
        logic d1_done;
        string tag;
        tag = $sformatf("v%0d", idx);
        i0.LS_control = v.ctl;  i1.LS_control = v.ctl;
        i0.addr = v.addr;       i1.addr = v.addr;
        i0.mem_data_in = ~v.word; i1.mem_data_in = ~v.word;
        i0.start = 1'b1;        i1.start = 1'b1;
        @(posedge clk); #1;
        i0.start = 1'b0;        i1.start = 1'b0;
        i0.addr = 32'hFFFF_FFFC; i1.addr = 32'hFFFF_FFFC;
        i0.LS_control = 2'b00;  i1.LS_control = 2'b00;
        chk({tag, "_addr0"}, i0.mem_addr, v.addr);
        chk({tag, "_addr1"}, i1.mem_addr, v.addr);
        rd0 = int'(i0.mem_rd);
        rd1 = int'(i1.mem_rd);
        n = 0;
        d1_done = 1'b0;
        for (int c = 1; c <= 10 && n == 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                i0.mem_data_in = v.word;
                i1.mem_data_in = v.word;
            end
            rd0 += int'(i0.mem_rd);
            rd1 += int'(i1.mem_rd);
            if (i0.done) begin
                n = c;
                d1_done = i1.done;
            end
        end
        chk({tag, "_latency"}, 32'(n), 32'd2);
        chk({tag, "_done1"}, 32'(d1_done), 32'd1);
        chk({tag, "_rd0"}, 32'(rd0), 32'd1);
        chk({tag, "_rd1"}, 32'(rd1), 32'd1);
        chk({tag, "_ls0"}, i0.LS_out, v.exp0);
        chk({tag, "_ls1"}, i1.LS_out, v.exp1);
        chk({tag, "_mdr0"}, i0.mdr_out, v.word);
        chk({tag, "_mdr1"}, i1.mdr_out, v.word);
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, 32'(i0.done), 32'd0);
        chk({tag, "_idle"}, 32'(i0.busy), 32'd0);
        chk({tag, "_hold"}, i0.LS_out, v.exp0);
    endtask

    initial begin
        int n, rd, bad;
        vecs[0] = '{2'b00, 32'h0000_0040, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{2'b01, 32'h0000_0100, 32'h1234_80F6, 32'h0000_80F6, 32'hFFFF_80F6};
        vecs[2] = '{2'b10, 32'h0000_0103, 32'h1234_80F6, 32'h0000_00F6, 32'hFFFF_FFF6};
        vecs[3] = '{2'b11, 32'h0000_0200, 32'hCAFE_0001, 32'hCAFE_0001, 32'hCAFE_0001};
        vecs[4] = '{2'b01, 32'h0000_0202, 32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_7FFF};
        vecs[5] = '{2'b10, 32'h0000_0301, 32'hABCD_1280, 32'h0000_0080, 32'hFFFF_FF80};
        vecs[6] = '{2'b10, 32'h0000_0302, 32'h5555_AA7F, 32'h0000_007F, 32'h0000_007F};

        i0.start = 1'b1; i1.start = 1'b1; i2.start = 1'b1;
        i0.LS_control = 2'b01; i1.LS_control = 2'b10; i2.LS_control = 2'b00;
        i0.addr = $urandom; i1.addr = $urandom; i2.addr = $urandom;
        i0.mem_data_in = $urandom; i1.mem_data_in = $urandom; i2.mem_data_in = $urandom;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr0", i0.mem_addr, 32'h0);
        chk("rst_addr2", i2.mem_addr, 32'h0);
        chk("rst_rd", {29'h0, i0.mem_rd, i1.mem_rd, i2.mem_rd}, 32'h0);
        chk("rst_busy", {29'h0, i0.busy, i1.busy, i2.busy}, 32'h0);
        chk("rst_done", {29'h0, i0.done, i1.done, i2.done}, 32'h0);
        chk("rst_ls", i0.LS_out | i1.LS_out | i2.LS_out, 32'h0);
        chk("rst_mdr", i0.mdr_out | i1.mdr_out | i2.mdr_out, 32'h0);
        i0.start = 1'b0; i1.start = 1'b0; i2.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", {29'h0, i0.busy, i1.busy, i2.busy}, 32'h0);
        chk("post_rst_rd", {29'h0, i0.mem_rd, i1.mem_rd, i2.mem_rd}, 32'h0);

        for (int k = 0; k < 7; k++) run_pair(k, vecs[k]);

        // latency 3: start retriggered during WAIT and during DONE must be ignored
        i2.addr = 32'h0000_0200; i2.LS_control = 2'b00; i2.mem_data_in = 32'h1122_3344;
        i2.start = 1'b1;
        @(posedge clk); #1;
        i2.start = 1'b0;
        rd = int'(i2.mem_rd);
        n = 0;
        bad = 0;
        for (int c = 1; c <= 12 && n == 0; c++) begin
            @(posedge clk); #1;
            rd += int'(i2.mem_rd);
            if (i2.mem_addr !== 32'h0000_0200) bad++;
            if (c == 2) begin
                i2.start = 1'b1; i2.addr = 32'h0000_0999; i2.LS_control = 2'b10;
            end
            if (c == 3) i2.start = 1'b0;
            if (i2.done) n = c;
        end
        chk("l3_latency", 32'(n), 32'd4);
        chk("l3_rd_count", 32'(rd), 32'd1);
        chk("l3_addr_stable", 32'(bad), 32'd0);
        chk("l3_ls", i2.LS_out, 32'h1122_3344);
        chk("l3_mdr", i2.mdr_out, 32'h1122_3344);
        i2.start = 1'b1; i2.addr = 32'h0000_0777;
        @(posedge clk); #1;
        i2.start = 1'b0;
        chk("l3_done_start_busy", 32'(i2.busy), 32'd0);
        chk("l3_done_start_addr", i2.mem_addr, 32'h0000_0200);
        @(posedge clk); #1;
        chk("l3_no_requeue", {30'h0, i2.busy, i2.mem_rd}, 32'h0);

        // abort during WAIT
        i2.addr = 32'h0000_0300; i2.LS_control = 2'b10; i2.mem_data_in = 32'h55AA_55C3;
        i2.start = 1'b1;
        @(posedge clk); #1;
        i2.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(i2.busy), 32'd0);
        chk("abort_addr", i2.mem_addr, 32'h0);
        chk("abort_ls", i2.LS_out, 32'h0);
        chk("abort_mdr", i2.mdr_out, 32'h0);
        chk("abort_ls0", i0.LS_out, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            n += int'(i2.done) + int'(i2.busy);
        end
        chk("abort_no_done", 32'(n), 32'd0);

        i2.addr = 32'h0000_0304; i2.LS_control = 2'b10; i2.mem_data_in = 32'h0000_00A5;
        i2.start = 1'b1;
        @(posedge clk); #1;
        i2.start = 1'b0;
        n = 0;
        for (int c = 1; c <= 12 && n == 0; c++) begin
            @(posedge clk); #1;
            if (i2.done) n = c;
        end
        chk("fresh_latency", 32'(n), 32'd4);
        chk("fresh_ls", i2.LS_out, 32'hFFFF_FFA5);
        chk("fresh_mdr", i2.mdr_out, 32'h0000_00A5);
        chk("fresh_addr", i2.mem_addr, 32'h0000_0304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_control_seq.md
Name: load_control_seq

Overview:
Sequential load unit that performs one memory read per request and formats the returned word for lw, lh or lb. It captures the address and type at start, drives a single-cycle read strobe, and waits a fixed memory latency. It then registers the raw word (mdr_out) and the formatted result (LS_out) and pulses done. It is the read-side counterpart of the store merge unit: lh/lb take the low half/byte of the fetched word, the same lanes the store path overwrites. mdr_out feeds the store merge as its memory-word input for read-modify-write.

Parameters:
MEM_LATENCY, 1, cycles from the mem_rd cycle to valid mem_data_in (legal range 1..15)
SIGN_EXT, 0, 0 = zero-extend lh/lb results; 1 = sign-extend from bit 15 / bit 7

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  load request; sampled only in IDLE
LS_control  input  2  00 lw, 01 lh, 10 lb, 11 reserved (treated as lw)
addr  input  32  byte address of the load
mem_data_in  input  32  memory read data
mem_addr  output  32  address driven to memory
mem_rd  output  1  read strobe, one cycle per load
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; LS_out/mdr_out valid
LS_out  output  32  formatted load result, held until next capture
mdr_out  output  32  raw captured memory word, held until next capture

Behaviour:
- Reset: clock and reset are fixed as one clock, asynchronous active-low reset. Asserting reset forces IDLE immediately, without waiting for a clock edge. Outputs under reset: mem_addr=0, mem_rd=0, busy=0, done=0, LS_out=0, mdr_out=0, latency counter=0. Deassertion is synchronous to clk.
- States: IDLE, REQ, WAIT, DONE (2-bit encoding from the shared header).
- IDLE: if start=1 at a rising edge, register addr→mem_addr and LS_control→type_q, then go to REQ. If start=0, stay in IDLE.
- REQ: mem_rd=1 for exactly this cycle. Load the counter with MEM_LATENCY-1. Go to WAIT.
- WAIT: mem_rd=0. If counter≠0, decrement and stay.
  - If counter=0, at that edge register mem_data_in→mdr_out and format(mem_data_in,type_q)→LS_out, then go to DONE.
  - This gives exactly MEM_LATENCY WAIT cycles.
- DONE: done=1 for this cycle only. Go to IDLE.
- Latency: the start edge is E0. done is high in the cycle after edge E(1+MEM_LATENCY), i.e. cycle 3 after start for MEM_LATENCY=1. Next start is accepted at the edge ending DONE+1 (IDLE). Throughput: one load per MEM_LATENCY+3 cycles.
- start is ignored while busy=1, including during DONE; there is no queueing.
- mem_addr stays stable from the REQ cycle through DONE and holds its last value in IDLE. addr and LS_control changes after the start edge have no effect.
- Format rules:
  - lw (00 or 11): LS_out = word.
  - lh: {16 fill, word[15:0]}.
  - lb: {24 fill, word[7:0]}.
  - Fill is zeros when SIGN_EXT=0, otherwise the replicated bit 15 / bit 7.
  - addr[1:0] is not used for lane selection and raises no misalignment flag.
- mdr_out always holds the unformatted word, regardless of type.
- Reset mid-operation (REQ/WAIT/DONE): the load is aborted. No done pulse, and all outputs take their reset values.
- mem_data_in is sampled only at the final WAIT edge; its value in any other cycle is don't-care.

Decomposition:
- Shared header load_store_defs.vh holds:
  - LS/SS type encodings (LS_WORD=2'b00, LS_HALF=2'b01, LS_BYTE=2'b10), shared with the store merge unit.
  - FSM state localparams.
- One combinational sub-module, load_format: inputs word[31:0], type[1:0], parameter SIGN_EXT; output formatted[31:0]. The parent registers its output into LS_out.
- The counter and FSM stay in load_control_seq.

Test Plan:
- Reset: hold reset=0 with start=1 and random inputs → all outputs 0, busy=0. After release with start=0, state remains IDLE.
- lw, MEM_LATENCY=1: start, addr=0x0000_0040, LS_control=00, mem_data_in=0xDEAD_BEEF → mem_rd high one cycle with mem_addr=0x40. done is in cycle 3 after start with LS_out=0xDEADBEEF and mdr_out=0xDEADBEEF.
- lh/lb formatting, word=0x1234_80F6:
  - SIGN_EXT=0: lh→0x0000_80F6, lb→0x0000_00F6.
  - SIGN_EXT=1: lh→0xFFFF_80F6, lb→0xFFFF_FFF6.
  - mdr_out=0x1234_80F6 in every case.
- Latency/ignored start, MEM_LATENCY=3: pulse start again during WAIT with a different addr → exactly one mem_rd, done in cycle 5 after the first start, mem_addr unchanged.
- Reserved type: LS_control=11, word=0xCAFE_0001 → LS_out=0xCAFE_0001.
- Reset mid-op: assert reset during WAIT → outputs clear immediately and no done follows. A fresh lb load then completes normally.
